parking_sensor_fsm: RTL and testbench
=====================================

# parking_sensor_fsm

Front end of the parking-lot occupancy counter. Takes the two raw photo-sensor beams at the lot gate and synchronizes and debounces each one. A sequence FSM tracks the debounced pair and emits one-cycle `inc`/`dec` pulses for each completed car entry or exit. It sits directly upstream of the occupancy counter, and its `inc`/`dec` connect to that counter's `inc`/`dec` inputs.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles required before a debounced sensor changes. Legal range is ≥1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a`  in  1  raw outer beam, 1 = blocked. Asynchronous to `clk`.
- `b`  in  1  raw inner beam, 1 = blocked. Asynchronous to `clk`.
- `inc`  out  1  registered; one-cycle pulse per completed entry.
- `dec`  out  1  registered; one-cycle pulse per completed exit.
- `a_db`  out  1  debounced `a`.
- `b_db`  out  1  debounced `b`.
- `busy`  out  1  registered; 1 whenever FSM ≠ IDLE.
- `seq_err`  out  1  registered; one-cycle pulse on an illegal transition.

## Operation
- **Reset:** while `reset_n`=0, all registers clear asynchronously.
  - Sync flops = 0, `a_db`=`b_db`=0, debounce counters = 0.
  - FSM = IDLE; `inc`=`dec`=`busy`=`seq_err`=0.
- **Per-sensor front end:** 2-flop synchronizer (s1→s2), then debounce. Counter width is clog2(DB_CYCLES), minimum 1.
  - Each edge, if s2 ≠ db and cnt = DB_CYCLES-1: db←s2 and cnt←0.
  - Each edge, if s2 ≠ db and cnt < DB_CYCLES-1: cnt←cnt+1.
  - Each edge, if s2 = db: cnt←0. Any bounce shorter than DB_CYCLES therefore has no effect.
- **FSM:** operates on the pair p = {a_db, b_db}. States are IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT.
  - **IDLE:** 10→EN_A; 01→EX_B; 00 stay; 11→WAIT with `seq_err`.
  - **EN_A:** 11→EN_AB; 00→IDLE (abort); 10 stay; 01→WAIT with `seq_err`.
  - **EN_AB:** 01→EN_B; 10→EN_A (car backs up); 11 stay; 00→WAIT with `seq_err`.
  - **EN_B:** 00→IDLE and `inc`←1; 11→EN_AB; 01 stay; 10→WAIT with `seq_err`.
  - **Exit path** mirrors entry: EX_B (01) → EX_AB (11) → EX_A (10) → 00 gives IDLE and `dec`←1. Back-up and abort rules are mirrored, including EX_B with 00→IDLE and no pulse.
  - **WAIT:** stay until p=00, then →IDLE. No pulse ever leaves WAIT.
- **Output registers:**
  - `inc`, `dec`, `seq_err` are registered alongside the state transition and forced to 0 on every other edge, so each pulse is exactly one cycle wide.
  - `inc` and `dec` are never high in the same cycle.
- **Aborts:** a pedestrian or a car that reverses out (any return to 00 before the final phase) produces no pulse.
- **Reset mid-sequence:** the sequence is discarded. After release the FSM starts from IDLE and uses the current p, so a leftover 01→00 tail follows the exit path and produces no `dec`.

## Timing
- **Debounce latency:** a raw edge held stable appears on `*_db` after the (DB_CYCLES+2)th rising edge.
- **FSM latency:** the FSM reacts to `*_db` on the next edge.
- **Pulse latency:** `inc`/`dec` go high DB_CYCLES+3 edges after the final raw beam release and stay high for exactly 1 cycle.
- **Sequence phases:** each phase (10, 11, 01) must persist ≥ DB_CYCLES+2 cycles to be seen.
- **Simultaneous raw changes:** if `a` and `b` change together, the two debouncers are independent. If `a_db` and `b_db` update on the same edge, the FSM sees a two-bit jump and applies the illegal-transition rules.
- **Throughput:** one event per full sequence. Back-to-back cars are handled because IDLE accepts a new 10 on the edge after the pulse.

## Test plan
- **Reset:** assert `reset_n`=0 mid-clock.
  - All outputs 0 immediately, before the next edge.
  - Release, then hold a=b=0 for 20 cycles: all outputs stay 0.
- **Entry, DB_CYCLES=4:** apply a,b = 10, 11, 01, 00, each held 10 cycles.
  - Exactly one `inc` pulse, 1 cycle wide, 7 edges after the final release. `dec`=0 throughout.
  - `busy`=1 from EN_A entry until the pulse edge.
- **Exit:** apply 01, 11, 10, 00, each held 10 cycles.
  - Exactly one `dec` pulse with the same latency. `inc`=0.
  - Two back-to-back exits give two `dec` pulses.
- **Glitch rejection:** pulse `a` high for 3 cycles, then low.
  - `a_db` stays 0; FSM stays IDLE; no pulses.
  - Repeat with a 6-cycle pulse: `a_db` rises, FSM goes to EN_A, and returns to IDLE with no pulse.
- **Back-up and abort:**
  - 10, 11, 10, 11, 01, 00 → one `inc`.
  - 10, 11, 10, 00 → no pulse and `busy` falls.
- **Illegal jump and reset mid-operation:**
  - Drive a and b high on the same cycle from 00 → `seq_err` pulses once, FSM in WAIT, no `inc` after 01, 00.
  - Reset while in EN_AB, then 01, 00 → no `inc` or `dec`.

Source files
------------

// File: rtl/parking_sensor_fsm.sv
// Parking-gate front end: synchronizes and debounces the two photo beams,
// then tracks the beam sequence and pulses inc/dec on each completed entry/exit.
module parking_sensor_fsm #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a,
    input  logic       b,
    output logic       inc,
    output logic       dec,
    output logic       a_db,
    output logic       b_db,
    output logic       busy,
    output logic       seq_err,
    output logic [2:0] dbg_state
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_AB = 3'd5,
        EX_A  = 3'd6,
        WAIT  = 3'd7
    } state_t;

    // Bit 1 carries beam a, bit 0 carries beam b, so r_db is the pair p directly.
    logic [1:0]          w_raw;
    logic [1:0]          r_s1;
    logic [1:0]          r_s2;
    logic [1:0]          r_db;
    logic [1:0][CW-1:0]  r_cnt;

    state_t r_state;
    logic   r_inc;
    logic   r_dec;
    logic   r_busy;
    logic   r_err;

    assign w_raw = {a, b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_db  <= '0;
            r_cnt <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] != r_db[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_db[i]  <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // busy only changes on transitions into or out of IDLE; pulses default low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    case (r_db)
                        2'b10: begin r_state <= EN_A; r_busy <= 1'b1; end
                        2'b01: begin r_state <= EX_B; r_busy <= 1'b1; end
                        2'b11: begin r_state <= WAIT; r_busy <= 1'b1; r_err <= 1'b1; end
                        default: r_state <= IDLE;
                    endcase
                end
                EN_A: begin
                    case (r_db)
                        2'b11: r_state <= EN_AB;
                        2'b00: begin r_state <= IDLE; r_busy <= 1'b0; end
                        2'b01: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EN_A;
                    endcase
                end
                EN_AB: begin
                    case (r_db)
                        2'b01: r_state <= EN_B;
                        2'b10: r_state <= EN_A;
                        2'b00: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EN_AB;
                    endcase
                end
                EN_B: begin
                    case (r_db)
                        2'b00: begin r_state <= IDLE; r_busy <= 1'b0; r_inc <= 1'b1; end
                        2'b11: r_state <= EN_AB;
                        2'b10: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EN_B;
                    endcase
                end
                EX_B: begin
                    case (r_db)
                        2'b11: r_state <= EX_AB;
                        2'b00: begin r_state <= IDLE; r_busy <= 1'b0; end
                        2'b10: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EX_B;
                    endcase
                end
                EX_AB: begin
                    case (r_db)
                        2'b10: r_state <= EX_A;
                        2'b01: r_state <= EX_B;
                        2'b00: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EX_AB;
                    endcase
                end
                EX_A: begin
                    case (r_db)
                        2'b00: begin r_state <= IDLE; r_busy <= 1'b0; r_dec <= 1'b1; end
                        2'b11: r_state <= EX_AB;
                        2'b01: begin r_state <= WAIT; r_err <= 1'b1; end
                        default: r_state <= EX_A;
                    endcase
                end
                WAIT: begin
                    if (r_db == 2'b00) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inc       = r_inc;
    assign dec       = r_dec;
    assign a_db      = r_db[1];
    assign b_db      = r_db[0];
    assign busy      = r_busy;
    assign seq_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Bench for parking_sensor_fsm: beam sequences drive a pulse scoreboard keyed
// by the cycle each inc/dec/seq_err pulse must appear on.
`timescale 1ns/1ps
module tb_parking_sensor_fsm;
    localparam int DB = 4;
    localparam int LAT = DB + 3;
    localparam logic [3:0] K_INC = 4'd1;
    localparam logic [3:0] K_DEC = 4'd2;
    localparam logic [3:0] K_ERR = 4'd4;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EN_A  = 3'd1;
    localparam logic [2:0] S_EN_AB = 3'd2;
    localparam logic [2:0] S_EX_B  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd7;

    logic       clk;
    logic       reset_n;
    logic       a;
    logic       b;
    logic       inc;
    logic       dec;
    logic       a_db;
    logic       b_db;
    logic       busy;
    logic       seq_err;
    logic [2:0] dbg_state;

    int          checks;
    int          failures;
    int unsigned cyc;
    logic [31:0] exp_q[$];

    parking_sensor_fsm #(.DB_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b),
        .inc(inc), .dec(dec), .a_db(a_db), .b_db(b_db),
        .busy(busy), .seq_err(seq_err), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: every pulse cycle must match the head of the expected queue
    always @(negedge clk) begin
        logic [31:0] got;
        if (inc || dec || seq_err) begin
            got = {cyc[27:0], 1'b0, seq_err, dec, inc};
            if (exp_q.size() == 0) check("unexpected_pulse", got, 32'h0);
            else                   check("pulse", got, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic phase(input logic va, input logic vb, input int hold);
        a = va;
        b = vb;
        wait_cycles(hold);
    endtask

    task automatic expect_pulse(input logic [3:0] kind);
        int unsigned t;
        t = cyc + LAT;
        exp_q.push_back({t[27:0], kind});
    endtask

    task automatic check_drained(input string tag);
        check(tag, exp_q.size(), 0);
    endtask

    logic [31:0] acc;

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        a        = 1'b0;
        b        = 1'b0;
        reset_n  = 1'b0;
        wait_cycles(3);
        check("reset_outputs", {25'd0, inc, dec, a_db, b_db, busy, seq_err, 1'b0}, 32'h0);
        check("reset_state", dbg_state, S_IDLE);
        reset_n = 1'b1;

        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | {25'd0, inc, dec, a_db, b_db, busy, seq_err, dbg_state != S_IDLE};
        end
        check("idle_quiet", acc, 32'h0);

        // entry
        phase(1, 0, 10);
        check("entry_en_a", dbg_state, S_EN_A);
        check("entry_busy", busy, 1'b1);
        phase(1, 1, 10);
        phase(0, 1, 10);
        expect_pulse(K_INC);
        phase(0, 0, 10);
        check_drained("entry_drained");
        check("entry_busy_fall", busy, 1'b0);

        // two back-to-back exits
        for (int n = 0; n < 2; n++) begin
            phase(0, 1, 10);
            check("exit_ex_b", dbg_state, S_EX_B);
            phase(1, 1, 10);
            phase(1, 0, 10);
            expect_pulse(K_DEC);
            phase(0, 0, 10);
        end
        check_drained("exit_drained");

        // short glitch on a
        acc = 0;
        a = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) a = 1'b0;
            @(negedge clk);
            acc = acc | {30'd0, a_db, dbg_state != S_IDLE};
        end
        check("glitch_3_rejected", acc, 32'h0);

        // 6-cycle pulse passes the debouncer, then aborts
        a = 1'b1;
        wait_cycles(6);
        check("glitch_6_a_db", a_db, 1'b1);
        a = 1'b0;
        wait_cycles(1);
        check("glitch_6_en_a", dbg_state, S_EN_A);
        wait_cycles(15);
        check("glitch_6_idle", dbg_state, S_IDLE);
        check_drained("glitch_drained");

        // back-up then complete entry
        phase(1, 0, 10);
        phase(1, 1, 10);
        phase(1, 0, 10);
        check("backup_en_a", dbg_state, S_EN_A);
        phase(1, 1, 10);
        phase(0, 1, 10);
        expect_pulse(K_INC);
        phase(0, 0, 10);
        check_drained("backup_drained");

        // reversal out of the gate
        phase(1, 0, 10);
        phase(1, 1, 10);
        phase(1, 0, 10);
        phase(0, 0, 10);
        check("abort_busy", busy, 1'b0);
        check_drained("abort_drained");

        // illegal two-bit jump
        expect_pulse(K_ERR);
        phase(1, 1, 10);
        check("illegal_wait", dbg_state, S_WAIT);
        phase(0, 1, 10);
        check("illegal_still_wait", dbg_state, S_WAIT);
        phase(0, 0, 10);
        check("illegal_idle", dbg_state, S_IDLE);
        check_drained("illegal_drained");

        // reset while in EN_AB discards the sequence
        phase(1, 0, 10);
        phase(1, 1, 10);
        check("midrst_en_ab", dbg_state, S_EN_AB);
        #2;
        reset_n = 1'b0;
        a = 1'b0;
        #1;
        check("midrst_async_clear", {25'd0, inc, dec, a_db, b_db, busy, seq_err, 1'b0}, 32'h0);
        check("midrst_async_state", dbg_state, S_IDLE);
        wait_cycles(2);
        reset_n = 1'b1;
        phase(0, 1, 10);
        check("midrst_ex_b", dbg_state, S_EX_B);
        phase(0, 0, 10);
        check("midrst_idle", dbg_state, S_IDLE);
        check_drained("midrst_drained");

        // random-length legal entry/exit phases
        for (int n = 0; n < 4; n++) begin
            logic ent;
            ent = 1'($urandom_range(0, 1));
            phase(ent, ~ent, $urandom_range(DB + 3, 12));
            phase(1, 1, $urandom_range(DB + 3, 12));
            phase(~ent, ent, $urandom_range(DB + 3, 12));
            expect_pulse(ent ? K_INC : K_DEC);
            phase(0, 0, $urandom_range(DB + 4, 12));
        end
        check_drained("random_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
